// File: rtl/shift_register_frame.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : shift_register_frame                                           |
// | Purpose : universal shift register with frame counter for the SPI path   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module shift_register_frame #(
    parameter  int WIDTH     = 8,
    parameter  int FRAME_LEN = WIDTH,
    localparam int CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_mode,
    input  logic [1:0]       i_out_mode,
    input  logic [WIDTH-1:0] i_parallel,
    input  logic             i_serial,
    output wire  [WIDTH-1:0] o_parallel,
    output logic             o_serial,
    output logic [CW-1:0]    o_count,
    output logic             o_done,
    output logic [WIDTH-1:0] o_frame
);

    localparam logic [1:0]    c_MODE_HOLD  = 2'b00;
    localparam logic [1:0]    c_MODE_RIGHT = 2'b01;
    localparam logic [1:0]    c_MODE_LEFT  = 2'b10;
    localparam logic [1:0]    c_MODE_LOAD  = 2'b11;
    localparam logic [CW-1:0] c_LAST       = CW'(FRAME_LEN - 1);

    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] r_frame;
    logic [CW-1:0]    r_count;
    logic             r_done;
    logic [WIDTH-1:0] w_next;
    logic             w_shift;

    always_comb begin
        w_next   = r_reg;
        w_shift  = 1'b0;
        o_serial = 1'b0;
        case (i_mode)
            c_MODE_RIGHT: begin
                w_next   = {i_serial, r_reg[WIDTH-1:1]};
                w_shift  = 1'b1;
                o_serial = r_reg[0];
            end
            c_MODE_LEFT: begin
                w_next   = {r_reg[WIDTH-2:0], i_serial};
                w_shift  = 1'b1;
                o_serial = r_reg[WIDTH-1];
            end
            c_MODE_LOAD: w_next = i_parallel;
            c_MODE_HOLD: w_next = r_reg;
            default:     w_next = r_reg;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_reg   <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_frame <= '0;
        end else begin
            r_reg  <= w_next;
            r_done <= 1'b0;
            if (i_mode == c_MODE_LOAD) begin
                // A load abandons whatever partial frame was in progress
                r_count <= '0;
            end else if (w_shift) begin
                if (r_count == c_LAST) begin
                    r_count <= '0;
                    r_done  <= 1'b1;
                    r_frame <= w_next;
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end
        end
    end

    assign o_parallel = i_out_mode[1] ? {WIDTH{1'bz}} :
                        (i_out_mode[0] ? {WIDTH{1'b0}} : r_reg);
    assign o_count    = r_count;
    assign o_done     = r_done;
    assign o_frame    = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_shift_register_frame.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_shift_register_frame                                        |
// | Purpose : self-checking bench for shift_register_frame (8/8 and 16/12)   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_shift_register_frame;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // DUT1: WIDTH=8, FRAME_LEN=8
    logic       rst1 = 1'b1, ser1 = 1'b0;
    logic [1:0] mode1 = 2'b00, omode1 = 2'b00;
    logic [7:0] par_in1 = 8'h00;
    wire  [7:0] par1;
    logic       so1, done1;
    logic [3:0] cnt1;
    logic [7:0] frame1;

    // Hi-Z is observed through weak pull-ups on the bus
    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup pu (par1[i]);
    end

    shift_register_frame #(.WIDTH(8), .FRAME_LEN(8)) u_dut1 (
        .i_clk(clk), .i_rst(rst1), .i_mode(mode1), .i_out_mode(omode1),
        .i_parallel(par_in1), .i_serial(ser1), .o_parallel(par1),
        .o_serial(so1), .o_count(cnt1), .o_done(done1), .o_frame(frame1));

    // DUT2: WIDTH=16, FRAME_LEN=12
    logic        rst2 = 1'b1, ser2 = 1'b0;
    logic [1:0]  mode2 = 2'b00;
    logic [15:0] par_in2 = 16'h0000;
    wire  [15:0] par2;
    logic        so2, done2;
    logic [3:0]  cnt2;
    logic [15:0] frame2;

    shift_register_frame #(.WIDTH(16), .FRAME_LEN(12)) u_dut2 (
        .i_clk(clk), .i_rst(rst2), .i_mode(mode2), .i_out_mode(2'b00),
        .i_parallel(par_in2), .i_serial(ser2), .o_parallel(par2),
        .o_serial(so2), .o_count(cnt2), .o_done(done2), .o_frame(frame2));

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    logic [15:0] m1_reg, m1_frame, m2_reg, m2_frame;
    int          m1_cnt, m2_cnt;
    bit          m1_done, m2_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic mstep(inout logic [15:0] r, inout int cnt, inout bit dn, inout logic [15:0] fr,
                         input int w, input int fl, input bit rs, input logic [1:0] md,
                         input bit s, input logic [15:0] p);
        logic [15:0] mask;
        mask = 16'((32'd1 << w) - 1);
        dn   = 1'b0;
        if (rs) begin
            r = '0; cnt = 0; fr = '0;
        end else if (md == 2'b11) begin
            r = p & mask; cnt = 0;
        end else if (md != 2'b00) begin
            if (md == 2'b01) r = (r >> 1) | (16'(s) << (w - 1));
            else             r = ((r << 1) | 16'(s)) & mask;
            cnt = cnt + 1;
            if (cnt == fl) begin
                cnt = 0; dn = 1'b1; fr = r;
            end
        end
    endtask

    function automatic logic ser_of(input logic [1:0] md, input logic [15:0] r, input int w);
        if (md == 2'b01) return r[0];
        if (md == 2'b10) return r[w-1];
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic [7:0] exp_par;
            exp_par = (omode1 == 2'b00) ? m1_reg[7:0] : ((omode1 == 2'b01) ? 8'h00 : 8'hFF);
            check("dut1 o_parallel", 32'(par1), 32'(exp_par));
            check("dut1 o_serial",   32'(so1), 32'(ser_of(mode1, m1_reg, 8)));
            check("dut1 o_count",    32'(cnt1), 32'(m1_cnt));
            check("dut1 o_done",     32'(done1), 32'(m1_done));
            check("dut1 o_frame",    32'(frame1), 32'(m1_frame[7:0]));
            check("dut2 o_parallel", 32'(par2), 32'(m2_reg));
            check("dut2 o_serial",   32'(so2), 32'(ser_of(mode2, m2_reg, 16)));
            check("dut2 o_count",    32'(cnt2), 32'(m2_cnt));
            check("dut2 o_done",     32'(done2), 32'(m2_done));
            check("dut2 o_frame",    32'(frame2), 32'(m2_frame));
        end
    end

    logic last_so1;
    int   ndone1 = 0;
    int   step_no2 = 0;
    int   hits2[$];

    // One clock: inputs already set, capture pre-edge serial, advance model
    task automatic step();
        #1;
        last_so1 = so1;
        @(posedge clk);
        mstep(m1_reg, m1_cnt, m1_done, m1_frame, 8, 8, rst1, mode1, ser1, {8'h00, par_in1});
        mstep(m2_reg, m2_cnt, m2_done, m2_frame, 16, 12, rst2, mode2, ser2, par_in2);
        #1;
        if (done1) ndone1++;
        if (!rst2) begin
            step_no2++;
            if (done2) hits2.push_back(step_no2);
        end
    endtask

    task automatic shifts(input logic [1:0] md, input logic [7:0] bits, input int n);
        mode1 = md;
        for (int i = 0; i < n; i++) begin
            ser1 = bits[i % 8];
            step();
        end
        mode1 = 2'b00;
        ser1  = 1'b0;
    endtask

    task automatic load(input logic [7:0] v);
        mode1 = 2'b11; par_in1 = v;
        step();
        mode1 = 2'b00;
    endtask

    initial begin
        logic [7:0] seq;
        logic [7:0] pat;
        logic [15:0] pat2;

        step();
        chk_en = 1'b1;
        step();

        // Reset after a random load and a few shifts
        rst1 = 1'b0;
        load(8'($urandom));
        shifts(2'b01, 8'h5B, 3);
        rst1 = 1'b1;
        for (int i = 0; i < 16; i++) step();
        rst1 = 1'b0;
        check("rst o_parallel", 32'(par1), 32'h00);
        check("rst o_count", 32'(cnt1), 32'h0);
        check("rst o_done", 32'(done1), 32'h0);
        check("rst o_frame", 32'(frame1), 32'h00);

        // Load A5, shift right 3C in LSB first
        load(8'hA5);
        pat = 8'h3C;
        mode1 = 2'b01;
        for (int i = 0; i < 8; i++) begin
            ser1 = pat[i];
            step();
            seq[i] = last_so1;
        end
        mode1 = 2'b00;
        check("right serial seq", 32'(seq), 32'hA5);
        check("right o_parallel", 32'(par1), 32'h3C);
        check("right o_count", 32'(cnt1), 32'h0);
        check("right o_done", 32'(done1), 32'h1);
        check("right o_frame", 32'(frame1), 32'h3C);
        step();
        check("right done width", 32'(done1), 32'h0);

        // Shift left 0F in LSB first from zero
        load(8'h00);
        ndone1 = 0;
        shifts(2'b10, 8'h0F, 8);
        step();
        check("left o_parallel", 32'(par1), 32'hF0);
        check("left o_frame", 32'(frame1), 32'hF0);
        check("left done count", 32'(ndone1), 32'd1);

        // Abort by load, then a complete frame, then abort by reset
        ndone1 = 0;
        shifts(2'b01, 8'hFF, 5);
        load(8'h81);
        check("abort o_count", 32'(cnt1), 32'h0);
        check("abort done count", 32'(ndone1), 32'd0);
        shifts(2'b01, 8'h96, 8);
        step();
        check("post-abort done count", 32'(ndone1), 32'd1);
        ndone1 = 0;
        shifts(2'b01, 8'h00, 3);
        rst1 = 1'b1; step(); rst1 = 1'b0;
        step(); step();
        check("reset abort done count", 32'(ndone1), 32'd0);

        // Direction change mid-frame keeps counting
        ndone1 = 0;
        shifts(2'b01, 8'hC3, 3);
        shifts(2'b10, 8'h35, 5);
        step();
        check("mixed done count", 32'(ndone1), 32'd1);

        // Output control modes
        load(8'hFF);
        shifts(2'b01, 8'h01, 2);
        load(8'hFF);
        for (int m = 0; m < 4; m++) begin
            omode1 = 2'(m); step();
        end
        omode1 = 2'b01; #1;
        check("omode01 forced low", 32'(par1), 32'h00);
        check("omode01 o_count", 32'(cnt1), 32'h0);
        load(8'h5A);
        for (int m = 0; m < 4; m++) begin
            omode1 = 2'(m); step();
        end
        omode1 = 2'b10; #1;
        check("omode10 hi-Z", 32'(par1), 32'hFF);
        omode1 = 2'b00; #1;
        check("omode00 drive", 32'(par1), 32'h5A);

        // 16-bit / 12-shift frame, continuous right shift
        rst2 = 1'b0;
        mode2 = 2'b01;
        pat2 = 16'hB4E1;
        for (int i = 0; i < 24; i++) begin
            ser2 = pat2[i % 16];
            step();
        end
        mode2 = 2'b00;
        step();
        check("w16 done hits", 32'(hits2.size()), 32'd2);
        if (hits2.size() == 2) begin
            check("w16 first done", 32'(hits2[0]), 32'd12);
            check("w16 second done", 32'(hits2[1]), 32'd24);
        end
        check("w16 o_count", 32'(cnt2), 32'h0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
